// File: rtl/egg_timer_control_pkg.sv
// Shared encodings for the egg timer: FSM states, digit count and per-digit wrap values.
package egg_timer_control_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SET   = 2'b01,
    ST_RUN   = 2'b10,
    ST_ALARM = 2'b11
  } state_e;

  localparam logic [3:0] WRAP_SEC_ONES = 4'd9;
  localparam logic [3:0] WRAP_SEC_TENS = 4'd5;
  localparam logic [3:0] WRAP_MIN_ONES = 4'd9;
  localparam logic [3:0] WRAP_MIN_TENS = 4'd9;

  // Digit k occupies bits [4k+3:4k], sec-ones in the low nibble.
  localparam logic [15:0] WRAP_ALL = {WRAP_MIN_TENS, WRAP_MIN_ONES, WRAP_SEC_TENS, WRAP_SEC_ONES};

endpackage

// File: rtl/egg_timer_control_button_edge.sv
// Rising-edge detector for a debounced button level; edge is combinational, one cycle wide.
// History resets to 1 so a button held through reset never reports an edge.
module button_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= btn_i;
    end
  end

  assign edge_o = btn_i & ~prev_q;

endmodule

// File: rtl/egg_timer_control.sv
// Egg timer sequencer: button UI, setting editor, 1 Hz countdown borrow chain and alarm phase.
// Button responses land on the clock edge after the edge is seen; decrement strobes are combinational.
module egg_timer_control
  import egg_timer_control_pkg::*;
#(
  parameter int ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnMode,
  input  logic        btnNext,
  input  logic        btnInc,
  input  logic        btnStart,
  input  logic        tick,
  input  logic [15:0] running,
  output logic [15:0] setting,
  output logic        isSetting,
  output logic [3:0]  isDecrement,
  output logic [3:0]  isZero,
  output logic [3:0]  isDone,
  output logic [15:0] wrap,
  output logic [1:0]  sel,
  output logic        alarm,
  output logic [1:0]  state
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] setting_q, setting_d;
  logic [7:0]  acnt_q, acnt_d;

  logic mode_e, next_e, inc_e, start_e;
  logic any_edge, run_zero, dec_en;
  logic [3:0] cur_digit, cur_wrap;

  button_edge u_edge_mode  (.clk_i(clk), .rst_i(reset), .btn_i(btnMode),  .edge_o(mode_e));
  button_edge u_edge_next  (.clk_i(clk), .rst_i(reset), .btn_i(btnNext),  .edge_o(next_e));
  button_edge u_edge_inc   (.clk_i(clk), .rst_i(reset), .btn_i(btnInc),   .edge_o(inc_e));
  button_edge u_edge_start (.clk_i(clk), .rst_i(reset), .btn_i(btnStart), .edge_o(start_e));

  always_comb begin
    isZero = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      isZero[k] = (running[4*k +: 4] == 4'd0);
    end
  end

  assign isDone   = {1'b1, isZero[3], &isZero[3:2], &isZero[3:1]};
  assign run_zero = &isZero;
  assign any_edge = mode_e | next_e | inc_e | start_e;

  // Start wins over a coincident tick, and a zero count goes to ALARM without decrementing.
  assign dec_en      = (state_q == ST_RUN) & tick & ~start_e & ~run_zero;
  assign isDecrement = {4{dec_en}} & {&isZero[2:0], &isZero[1:0], isZero[0], 1'b1};

  assign cur_digit = setting_q[{sel_q, 2'b00} +: 4];
  assign cur_wrap  = WRAP_ALL[{sel_q, 2'b00} +: 4];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    setting_d = setting_q;
    acnt_d    = acnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mode_e) begin
          state_d   = ST_SET;
          setting_d = running;
        end else if (start_e && !run_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_SET: begin
        if (start_e) begin
          state_d = (setting_q != 16'd0) ? ST_RUN : ST_IDLE;
        end else if (mode_e) begin
          state_d = ST_IDLE;
        end else if (next_e) begin
          sel_d = sel_q + 2'd1;
        end else if (inc_e) begin
          setting_d[{sel_q, 2'b00} +: 4] = (cur_digit >= cur_wrap) ? 4'd0 : cur_digit + 4'd1;
        end
      end
      ST_RUN: begin
        if (start_e) begin
          state_d = ST_IDLE;
        end else if (run_zero) begin
          state_d = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (any_edge || (tick && acnt_q == ALARM_LAST)) begin
          state_d = ST_IDLE;
          acnt_d  = 8'd0;
        end else if (tick) begin
          acnt_d = acnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'd0;
      setting_q <= 16'd0;
      acnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      setting_q <= setting_d;
      acnt_q    <= acnt_d;
    end
  end

  assign setting   = setting_q;
  assign isSetting = (state_q == ST_SET);
  assign alarm     = (state_q == ST_ALARM);
  assign state     = state_q;
  assign sel       = sel_q;
  assign wrap      = WRAP_ALL;

endmodule
